// File: rtl/macro_parity_checker_pkg.sv
// rtl/macro_parity_checker_pkg.sv - parity-sense constants and bus-width helper shared by parity checkers
package macro_parity_pkg;

    typedef enum logic {
        SENSE_EVEN = 1'b0,
        SENSE_ODD  = 1'b1
    } parity_sense_e;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    function automatic int bus_width(input int data_width, input int lane_count);
        return data_width * lane_count;
    endfunction

endpackage

// File: rtl/macro_parity_checker_if.sv
// rtl/macro_parity_checker_if.sv - input/output beat handshake bundle for the parity checker
interface macro_parity_checker_if
    import macro_parity_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANE_COUNT = 4
);
    logic                                          s_valid;
    logic                                          s_ready;
    logic [bus_width(DATA_WIDTH, LANE_COUNT)-1:0]  s_data;
    logic [LANE_COUNT-1:0]                         s_parity;
    logic                                          m_valid;
    logic                                          m_ready;
    logic [bus_width(DATA_WIDTH, LANE_COUNT)-1:0]  m_data;
    logic [LANE_COUNT-1:0]                         m_err;

    modport slave (
        input  s_valid, s_data, s_parity, m_ready,
        output s_ready, m_valid, m_data, m_err
    );

    modport master (
        output s_valid, s_data, s_parity, m_ready,
        input  s_ready, m_valid, m_data, m_err
    );
endinterface

// File: rtl/macro_parity_checker_syndrome.sv
// rtl/macro_parity_checker_syndrome.sv - combinational per-lane parity syndrome (1 = lane failed)
module macro_parity_syndrome
    import macro_parity_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANE_COUNT = 4,
    parameter int ODD_PARITY = PARITY_EVEN
) (
    input  logic [bus_width(DATA_WIDTH, LANE_COUNT)-1:0] data,
    input  logic [LANE_COUNT-1:0]                        parity,
    output logic [LANE_COUNT-1:0]                        syn
);
    localparam parity_sense_e SENSE = (ODD_PARITY != 0) ? SENSE_ODD : SENSE_EVEN;

    always_comb begin
        syn = '0;
        for (int i = 0; i < LANE_COUNT; i++) begin
            syn[i] = (^data[i*DATA_WIDTH +: DATA_WIDTH]) ^ parity[i] ^ SENSE;
        end
    end
endmodule

// File: rtl/macro_parity_checker.sv
// rtl/macro_parity_checker.sv - streaming per-lane parity checker; MACRO_PARITY_CHECKER_ERRLOG_EN adds first-error log
module macro_parity_checker
    import macro_parity_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int LANE_COUNT    = 4,
    parameter int ODD_PARITY    = PARITY_EVEN,
    parameter int ERRCNT_WIDTH  = 8,
    parameter int BEATCNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    macro_parity_checker_if.slave    bus,
    input  logic                     err_clr,
    output logic                     err_flag,
    output logic [ERRCNT_WIDTH-1:0]  err_count,
    output logic                     log_valid,
    output logic [BEATCNT_WIDTH-1:0] log_beat,
    output logic [LANE_COUNT-1:0]    log_err
);
    localparam int BW = bus_width(DATA_WIDTH, LANE_COUNT);
    localparam logic [ERRCNT_WIDTH-1:0] CNT_MAX = '1;

    logic [LANE_COUNT-1:0]   syn;
    logic                    s_ready;
    logic                    accept;
    logic                    err_event;
    logic                    m_valid_q;
    logic [BW-1:0]           m_data_q;
    logic [LANE_COUNT-1:0]   m_err_q;
    logic                    err_flag_q;
    logic [ERRCNT_WIDTH-1:0] err_count_q;

    macro_parity_syndrome #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_COUNT (LANE_COUNT),
        .ODD_PARITY (ODD_PARITY)
    ) u_syndrome (
        .data   (bus.s_data),
        .parity (bus.s_parity),
        .syn    (syn)
    );

    // Only the registered m_valid and the downstream m_ready feed s_ready.
    assign s_ready   = !m_valid_q || bus.m_ready;
    assign accept    = bus.s_valid && s_ready;
    assign err_event = accept && (|syn);

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_err   = m_err_q;
    assign err_flag    = err_flag_q;
    assign err_count   = err_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_err_q   <= '0;
        end else if (accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= bus.s_data;
            m_err_q   <= syn;
        end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    // A clear coincident with an error event still counts that event.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (err_clr) begin
                err_flag_q  <= 1'b0;
                err_count_q <= '0;
            end
            if (err_event) begin
                err_flag_q <= 1'b1;
                if (err_clr) begin
                    err_count_q <= ERRCNT_WIDTH'(1);
                end else if (err_count_q != CNT_MAX) begin
                    err_count_q <= err_count_q + 1'b1;
                end
            end
        end
    end

`ifdef MACRO_PARITY_CHECKER_ERRLOG_EN
    logic [BEATCNT_WIDTH-1:0] beat_q;
    logic                     log_valid_q;
    logic [BEATCNT_WIDTH-1:0] log_beat_q;
    logic [LANE_COUNT-1:0]    log_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q <= '0;
        end else if (accept) begin
            beat_q <= beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            log_valid_q <= 1'b0;
            log_beat_q  <= '0;
            log_err_q   <= '0;
        end else begin
            if (err_clr) begin
                log_valid_q <= 1'b0;
                log_beat_q  <= '0;
                log_err_q   <= '0;
            end
            if (err_event && (err_clr || !log_valid_q)) begin
                log_valid_q <= 1'b1;
                log_beat_q  <= beat_q;
                log_err_q   <= syn;
            end
        end
    end

    assign log_valid = log_valid_q;
    assign log_beat  = log_beat_q;
    assign log_err   = log_err_q;
`else
    assign log_valid = 1'b0;
    assign log_beat  = '0;
    assign log_err   = '0;
`endif

endmodule

// File: tb/tb_macro_parity_checker.sv
// tb/tb_macro_parity_checker.sv - randomized bench with behavioural model for macro_parity_checker
module tb_macro_parity_checker;
    localparam int DW = 8;
    localparam int LC = 4;
    localparam int BW = DW * LC;
`ifdef MACRO_PARITY_CHECKER_ERRLOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic [BW-1:0] s_data;
    logic [LC-1:0] s_parity;
    logic          m_ready;
    logic          err_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    macro_parity_checker_if #(.DATA_WIDTH(DW), .LANE_COUNT(LC)) bus8 ();
    macro_parity_checker_if #(.DATA_WIDTH(DW), .LANE_COUNT(LC)) bus2 ();

    assign bus8.s_valid  = s_valid;
    assign bus8.s_data   = s_data;
    assign bus8.s_parity = s_parity;
    assign bus8.m_ready  = m_ready;
    assign bus2.s_valid  = s_valid;
    assign bus2.s_data   = s_data;
    assign bus2.s_parity = s_parity;
    assign bus2.m_ready  = m_ready;

    logic          flag8, flag2, logv8, logv2;
    logic [7:0]    cnt8;
    logic [1:0]    cnt2;
    logic [15:0]   logb8, logb2;
    logic [LC-1:0] loge8, loge2;

    macro_parity_checker #(.DATA_WIDTH(DW), .LANE_COUNT(LC), .ODD_PARITY(0),
                           .ERRCNT_WIDTH(8), .BEATCNT_WIDTH(16)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8), .err_clr(err_clr),
        .err_flag(flag8), .err_count(cnt8),
        .log_valid(logv8), .log_beat(logb8), .log_err(loge8)
    );

    macro_parity_checker #(.DATA_WIDTH(DW), .LANE_COUNT(LC), .ODD_PARITY(0),
                           .ERRCNT_WIDTH(2), .BEATCNT_WIDTH(16)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .err_clr(err_clr),
        .err_flag(flag2), .err_count(cnt2),
        .log_valid(logv2), .log_beat(logb2), .log_err(loge2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane fails when its data ones plus its parity bit give an odd total (even sense).
    function automatic logic [LC-1:0] ref_syn(input logic [BW-1:0] d, input logic [LC-1:0] p);
        logic [LC-1:0] r;
        logic [DW-1:0] lane;
        for (int i = 0; i < LC; i++) begin
            lane = d[i*DW +: DW];
            r[i] = ((($countones(lane) + int'(p[i])) % 2) != 0);
        end
        return r;
    endfunction

    function automatic logic [LC-1:0] good_parity(input logic [BW-1:0] d);
        logic [LC-1:0] r;
        logic [DW-1:0] lane;
        for (int i = 0; i < LC; i++) begin
            lane = d[i*DW +: DW];
            r[i] = ($countones(lane) % 2) != 0;
        end
        return r;
    endfunction

    logic          e_mvalid;
    logic [BW-1:0] e_mdata;
    logic [LC-1:0] e_merr;
    logic          e_flag;
    int            e_cnt8, e_cnt2, e_beat;
    logic          e_logv;
    int            e_logb;
    logic [LC-1:0] e_loge;

    always @(posedge clk) begin : model_and_compare
        logic          acc;
        logic [LC-1:0] syn;
        acc = s_valid && (!e_mvalid || m_ready);
        syn = ref_syn(s_data, s_parity);
        if (reset) begin
            e_mvalid = 0; e_mdata = '0; e_merr = '0;
            e_flag = 0; e_cnt8 = 0; e_cnt2 = 0; e_beat = 0;
            e_logv = 0; e_logb = 0; e_loge = '0;
        end else begin
            if (acc) begin
                e_mvalid = 1; e_mdata = s_data; e_merr = syn;
            end else if (m_ready) begin
                e_mvalid = 0;
            end
            if (err_clr) begin
                e_flag = 0; e_cnt8 = 0; e_cnt2 = 0;
                e_logv = 0; e_logb = 0; e_loge = '0;
            end
            if (acc && syn != 0) begin
                e_flag = 1;
                e_cnt8 = (e_cnt8 < 255) ? e_cnt8 + 1 : 255;
                e_cnt2 = (e_cnt2 < 3) ? e_cnt2 + 1 : 3;
                if (!e_logv) begin
                    e_logv = 1; e_logb = e_beat; e_loge = syn;
                end
            end
            if (acc) e_beat = (e_beat + 1) % 65536;
        end
        #1;
        check("m_valid", bus8.m_valid, e_mvalid);
        check("m_data", bus8.m_data, e_mdata);
        check("m_err", bus8.m_err, e_merr);
        check("s_ready", bus8.s_ready, !e_mvalid || m_ready);
        check("err_flag", flag8, e_flag);
        check("err_count8", cnt8, e_cnt8);
        check("err_count2", cnt2, e_cnt2);
        check("m_valid2", bus2.m_valid, e_mvalid);
        check("log_valid", logv8, LOG_EN ? e_logv : 1'b0);
        check("log_beat", logb8, LOG_EN ? e_logb : 0);
        check("log_err", loge8, LOG_EN ? e_loge : '0);
        check("log_err2", loge2, LOG_EN ? e_loge : '0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        reset = 1; s_valid = 0; s_data = '0; s_parity = '0; m_ready = 1; err_clr = 0;
        repeat (3) tick();
        reset = 0;
        check("rst_m_valid", bus8.m_valid, 0);
        check("rst_m_data", bus8.m_data, 0);
        check("rst_s_ready", bus8.s_ready, 1);
        check("rst_err_count", cnt8, 0);
        check("rst_log_valid", logv8, 0);

        // Clean even-parity beats; beat 5 has lane 2 parity flipped.
        for (int b = 0; b < 8; b++) begin
            s_valid = 1; s_data = 32'h0301_0700;
            s_parity = (b == 5) ? 4'b0010 : 4'b0110;
            tick();
            check("dir_m_valid", bus8.m_valid, 1);
            if (b < 5) begin
                check("dir_clean_err", bus8.m_err, 4'b0000);
                check("dir_clean_cnt", cnt8, 0);
            end else begin
                if (b == 5) check("dir_lane2_err", bus8.m_err, 4'b0100);
                check("dir_cnt1", cnt8, 1);
                check("dir_flag", flag8, 1);
            end
        end
        s_parity = 4'b0111;
        tick();
        check("lane0_err", bus8.m_err, 4'b0001);
        check("lane0_cnt", cnt8, 2);
        check("log_beat_kept", logb8, LOG_EN ? 5 : 0);
        check("log_err_kept", loge8, LOG_EN ? 4'b0100 : 4'b0000);

        // Backpressure: held beat stays put, next beat waits.
        s_data = 32'hA5A5_0F0F; s_parity = good_parity(32'hA5A5_0F0F); m_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_s_ready", bus8.s_ready, 0);
            check("stall_m_data", bus8.m_data, 32'h0301_0700);
        end
        m_ready = 1;
        tick();
        check("release_data", bus8.m_data, 32'hA5A5_0F0F);
        s_valid = 0;
        tick();
        check("release_drain", bus8.m_valid, 0);

        // Saturation on the 2-bit counter.
        err_clr = 1;
        tick();
        err_clr = 0;
        check("clr_cnt2", cnt2, 0);
        s_valid = 1; s_parity = good_parity(32'hA5A5_0F0F) ^ 4'b1000;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("sat_cnt2", cnt2, sat_exp[j]);
        end

        // Clear and failing accept in the same cycle.
        err_clr = 1;
        tick();
        err_clr = 0; s_valid = 0;
        check("clr_err_cnt8", cnt8, 1);
        check("clr_err_cnt2", cnt2, 1);
        check("clr_err_flag", flag8, 1);
        check("clr_err_logb", logb8, LOG_EN ? 15 : 0);
        tick();

        // Reset while a beat is held.
        s_valid = 1; m_ready = 0; s_parity = good_parity(s_data);
        tick();
        check("held_m_valid", bus8.m_valid, 1);
        reset = 1;
        tick();
        check("rst_drop_valid", bus8.m_valid, 0);
        check("rst_drop_cnt", cnt8, 0);
        check("rst_drop_flag", flag8, 0);
        check("rst_drop_ready", bus8.s_ready, 1);
        reset = 0; s_valid = 0; m_ready = 1;
        tick();

        for (int c = 0; c < 3000; c++) begin
            s_valid  = ($urandom % 4) != 0;
            m_ready  = ($urandom % 4) != 0;
            s_data   = $urandom;
            s_parity = good_parity(s_data);
            if ($urandom % 6 == 0) s_parity = s_parity ^ LC'($urandom);
            err_clr  = ($urandom % 40) == 0;
            reset    = ($urandom % 400) == 0;
            tick();
        end
        reset = 0; s_valid = 0; err_clr = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
